// File: rtl/player_link_tx.sv
// 8N1 serial transmitter for the local player code: frames every legal change of
// the selection and re-sends a non-zero code periodically for late-starting peers.
module player_link_tx #(
  parameter int CLKS_PER_BIT = 564,
  parameter int RESEND_CLKS  = 6_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] selected_player,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic [1:0] sent_code
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int RW = (RESEND_CLKS > 1) ? $clog2(RESEND_CLKS) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [RW-1:0] RES_LAST  = RW'(RESEND_CLKS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state, w_state_nx;
  logic [BW-1:0] r_baud, w_baud_nx;
  logic [2:0]    r_bit, w_bit_nx;
  logic [RW-1:0] r_resend, w_resend_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic [1:0]    r_last, w_last_nx;
  logic [1:0]    r_code, w_code_nx;
  logic [1:0]    r_sent, w_sent_nx;
  logic          w_change, w_resend, w_baud_end;
  logic [1:0]    w_frame_code;

  // A fresh legal value beats a due resend when both happen in the same cycle.
  assign w_change     = (selected_player != 2'b10) && (selected_player != r_last);
  assign w_resend     = (r_last != 2'b00) && (r_resend == RES_LAST);
  assign w_frame_code = w_change ? selected_player : r_last;
  assign w_baud_end   = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_resend <= '0;
      r_shift  <= '0;
      r_last   <= 2'b00;
      r_code   <= 2'b00;
      r_sent   <= 2'b00;
    end else begin
      r_state  <= w_state_nx;
      r_baud   <= w_baud_nx;
      r_bit    <= w_bit_nx;
      r_resend <= w_resend_nx;
      r_shift  <= w_shift_nx;
      r_last   <= w_last_nx;
      r_code   <= w_code_nx;
      r_sent   <= w_sent_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_baud_nx   = r_baud;
    w_bit_nx    = r_bit;
    w_resend_nx = '0;
    w_shift_nx  = r_shift;
    w_last_nx   = r_last;
    w_code_nx   = r_code;
    w_sent_nx   = r_sent;
    case (r_state)
      IDLE: begin
        w_baud_nx = '0;
        w_bit_nx  = '0;
        if (w_change || w_resend) begin
          w_state_nx = START;
          w_code_nx  = w_frame_code;
          w_last_nx  = w_frame_code;
          w_shift_nx = {4'hA, 2'b00, w_frame_code};
        end else if (r_last != 2'b00) begin
          w_resend_nx = r_resend + 1'b1;
        end
      end
      START: begin
        if (w_baud_end) begin
          w_state_nx = DATA;
          w_baud_nx  = '0;
        end else begin
          w_baud_nx = r_baud + 1'b1;
        end
      end
      DATA: begin
        if (w_baud_end) begin
          w_baud_nx  = '0;
          w_shift_nx = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nx = STOP;
            w_bit_nx   = '0;
          end else begin
            w_bit_nx = r_bit + 3'd1;
          end
        end else begin
          w_baud_nx = r_baud + 1'b1;
        end
      end
      STOP: begin
        if (w_baud_end) begin
          w_state_nx = IDLE;
          w_baud_nx  = '0;
          w_sent_nx  = r_code;
        end else begin
          w_baud_nx = r_baud + 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Outputs decode straight from state so an asynchronous reset idles the line at once.
  always_comb begin
    tx = 1'b1;
    case (r_state)
      START:   tx = 1'b0;
      DATA:    tx = r_shift[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == STOP) && w_baud_end;
  assign sent_code  = r_sent;

endmodule

// File: tb/tb_player_link_tx.sv
// Bench for player_link_tx: scenario tasks plus a time-based model of frames on the wire.
module tb_player_link_tx;
  localparam int CPB = 4;
  localparam int RES = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       tx, busy, fd;
  logic [1:0] sc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  player_link_tx #(.CLKS_PER_BIT(CPB), .RESEND_CLKS(RES)) dut (
    .clk(clk), .rst(rst), .selected_player(sel),
    .tx(tx), .busy(busy), .frame_done(fd), .sent_code(sc)
  );

  // Model: a frame is a 10*CPB-cycle window starting at cycle fs; idle stretches are
  // measured from ie, the first idle cycle after a frame.
  int         cyc = 0, fs = 0, ie = 0;
  bit         act = 1'b0;
  logic [1:0] m_last = 2'b00, m_code = 2'b00, m_sent = 2'b00;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      act = 1'b0; m_last = 2'b00; m_code = 2'b00; m_sent = 2'b00; ie = 0; cyc = 0;
    end else begin
      if (act) begin
        if (cyc == fs + 10*CPB - 1) begin
          act = 1'b0; ie = cyc + 1; m_sent = m_code;
        end
      end else if (sel != 2'b10 && sel != m_last) begin
        act = 1'b1; fs = cyc + 1; m_last = sel; m_code = sel;
      end else if (m_last != 2'b00 && cyc - ie == RES - 1) begin
        act = 1'b1; fs = cyc + 1; m_code = m_last;
      end
      cyc++;
    end
  end

  function automatic logic exp_tx();
    int off;
    logic [7:0] b;
    if (!act) return 1'b1;
    off = cyc - fs;
    b = {4'hA, 2'b00, m_code};
    if (off < CPB) return 1'b0;
    if (off >= 9*CPB) return 1'b1;
    return b[off/CPB - 1];
  endfunction

  function automatic logic exp_fd();
    return act && (cyc - fs == 10*CPB - 1);
  endfunction

  task automatic test_reset();
    int fdc = 0, lowc = 0;
    rst = 1'b0; sel = 2'b00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx, busy, fd, sc} !== 5'b10000) begin
      n_bad++; $display("FAIL reset_vals: got %b want 10000", {tx, busy, fd, sc});
    end
    rst = 1'b1;
    repeat (500) begin
      @(negedge clk);
      if (fd) fdc++;
      if (!tx || busy) lowc++;
    end
    n_cmp++;
    if (fdc !== 0) begin n_bad++; $display("FAIL idle_frame_done: got %0d pulses want 0", fdc); end
    n_cmp++;
    if (lowc !== 0) begin n_bad++; $display("FAIL idle_line: got %0d active cycles want 0", lowc); end
    n_cmp++;
    if (sc !== 2'b00) begin n_bad++; $display("FAIL idle_sent_code: got %b want 00", sc); end
  endtask

  task automatic test_first_frame();
    logic [7:0] b = 8'hA1;
    logic [4:0] exp;
    sel = 2'b01;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (k <= 4)       exp[4] = 1'b0;
      else if (k <= 36) exp[4] = b[(k-5)/4];
      else              exp[4] = 1'b1;
      exp[3]   = (k <= 40);
      exp[2]   = (k == 40);
      exp[1:0] = (k <= 40) ? 2'b00 : 2'b01;
      n_cmp++;
      if ({tx, busy, fd, sc} !== exp) begin
        n_bad++; $display("FAIL first_frame k=%0d: got %b want %b", k, {tx, busy, fd, sc}, exp);
      end
    end
  endtask

  task automatic test_change_mid_frame();
    int t = 0;
    logic [7:0] rx = 8'h00;
    while (!busy && t < 300) begin @(negedge clk); t++; end
    n_cmp++;
    if (!busy) begin n_bad++; $display("FAIL mid_wait_busy: got timeout want frame"); return; end
    repeat (9) @(negedge clk);
    sel = 2'b11;
    for (int k = 11; k <= 82; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({tx, busy, fd, sc} !== {exp_tx(), act, exp_fd(), m_sent}) begin
        n_bad++; $display("FAIL mid_model k=%0d: got %b want %b", k, {tx, busy, fd, sc},
                          {exp_tx(), act, exp_fd(), m_sent});
      end
      if (k >= 42 && k <= 81 && (k-42)%4 == 2 && (k-42)/4 >= 1 && (k-42)/4 <= 8)
        rx[(k-42)/4 - 1] = tx;
      if (k == 41) begin
        n_cmp++;
        if ({tx, busy, sc} !== 4'b1001) begin
          n_bad++; $display("FAIL mid_gap: got %b want 1001", {tx, busy, sc});
        end
      end
    end
    n_cmp++;
    if (rx !== 8'hA3) begin n_bad++; $display("FAIL mid_second_byte: got %h want a3", rx); end
    n_cmp++;
    if (sc !== 2'b11) begin n_bad++; $display("FAIL mid_sent_code: got %b want 11", sc); end
  endtask

  task automatic test_resend();
    int g = 0, p;
    while (!busy && g < 300) begin @(negedge clk); g++; end
    n_cmp++;
    if (g !== RES) begin n_bad++; $display("FAIL resend_gap: got %0d want %0d", g, RES); end
    repeat (2) begin
      p = 0;
      while (busy && p < 400) begin @(negedge clk); p++; end
      while (!busy && p < 400) begin @(negedge clk); p++; end
      n_cmp++;
      if (p !== RES + 10*CPB) begin
        n_bad++; $display("FAIL resend_period: got %0d want %0d", p, RES + 10*CPB);
      end
      n_cmp++;
      if ({tx, sc} !== {exp_tx(), m_sent} || m_code !== 2'b11) begin
        n_bad++; $display("FAIL resend_model: got %b want %b", {tx, sc}, {exp_tx(), m_sent});
      end
    end
  endtask

  task automatic test_illegal();
    int bc = 0;
    logic [1:0] q[$];
    logic prev_fd = 1'b0;
    sel = 2'b00;
    repeat (150) @(negedge clk);
    n_cmp++;
    if ({busy, sc} !== 3'b000) begin n_bad++; $display("FAIL zero_sent: got %b want 000", {busy, sc}); end
    sel = 2'b10;
    repeat (500) begin @(negedge clk); if (busy) bc++; end
    n_cmp++;
    if (bc !== 0) begin n_bad++; $display("FAIL illegal_code: got %0d busy cycles want 0", bc); end
    sel = 2'b01;
    @(negedge clk);
    n_cmp++;
    if ({tx, busy} !== 2'b01) begin n_bad++; $display("FAIL quick_start: got %b want 01", {tx, busy}); end
    @(negedge clk);
    sel = 2'b00;
    repeat (300) begin
      @(negedge clk);
      if (prev_fd) q.push_back(sc);
      prev_fd = fd;
    end
    n_cmp++;
    if (q.size() !== 2) begin
      n_bad++; $display("FAIL quick_frames: got %0d want 2", q.size());
    end else begin
      n_cmp++;
      if ({q[0], q[1]} !== 4'b0100) begin
        n_bad++; $display("FAIL quick_codes: got %b want 0100", {q[0], q[1]});
      end
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    logic [7:0] b = 8'hA1;
    logic exp;
    sel = 2'b01;
    while (!busy && t < 50) begin @(negedge clk); t++; end
    n_cmp++;
    if (!busy) begin n_bad++; $display("FAIL rmid_wait_busy: got timeout want frame"); return; end
    repeat (17) @(negedge clk);
    n_cmp++;
    if (tx !== b[3]) begin n_bad++; $display("FAIL rmid_bit3: got %b want %b", tx, b[3]); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({tx, busy, fd, sc} !== 5'b10000) begin
      n_bad++; $display("FAIL rmid_async: got %b want 10000", {tx, busy, fd, sc});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      exp = (k <= 4) ? 1'b0 : b[(k-5)/4];
      n_cmp++;
      if ({tx, busy} !== {exp, 1'b1}) begin
        n_bad++; $display("FAIL rmid_restart k=%0d: got %b want %b", k, {tx, busy}, {exp, 1'b1});
      end
    end
  endtask

  task automatic test_random();
    int hold = 0, shown = 0;
    repeat (3000) begin
      if (hold == 0) begin
        sel = 2'($urandom_range(0, 3));
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 260)) : int'($urandom_range(1, 30));
      end
      hold--;
      @(negedge clk);
      n_cmp++;
      if ({tx, busy, fd, sc} !== {exp_tx(), act, exp_fd(), m_sent}) begin
        n_bad++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random cyc=%0d: got %b want %b", cyc, {tx, busy, fd, sc},
                   {exp_tx(), act, exp_fd(), m_sent});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_change_mid_frame();
    test_resend();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
